// File: rtl/bus_interconnect.sv
// Single-master bus fabric: decodes the cpu address into slave regions,
// forwards one access at a time with a ready handshake, and turns unmapped,
// conflicting or timed-out accesses into an error completion that is logged.
//
// Handshake: the master holds read or write until a one-cycle ready pulse.
// A request is accepted only in IDLE while armed. The master re-arms the
// fabric by dropping both read and write for at least one cycle. A slave
// finishes by raising its own s_ready bit while it is selected.
module bus_interconnect #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 16,
    parameter int NUM_SLAVES = 4,
    parameter logic [NUM_SLAVES*ADDR_WIDTH-1:0] BASE_ADDRS =
        {20'h0FF00, 20'h08010, 20'h08000, 20'h00000},
    parameter logic [NUM_SLAVES*5-1:0] SIZE_LOG2 = {5'd8, 5'd4, 5'd4, 5'd11},
    parameter int TIMEOUT = 15
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [ADDR_WIDTH-1:0]            bus_addr,
    input  logic [DATA_WIDTH-1:0]            bus_wdata,
    output logic [DATA_WIDTH-1:0]            bus_rdata,
    input  logic                             read,
    input  logic                             write,
    output logic                             ready,
    output logic                             error,
    output logic [NUM_SLAVES-1:0]            s_sel,
    output logic [ADDR_WIDTH-1:0]            s_addr,
    output logic [DATA_WIDTH-1:0]            s_wdata,
    output logic                             s_read,
    output logic                             s_write,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_rdata,
    input  logic [NUM_SLAVES-1:0]            s_ready,
    output logic [ADDR_WIDTH-1:0]            err_addr,
    output logic [7:0]                       err_count
);

    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP, ERR} state_t;

    state_t                state;
    state_t                state_next;
    logic                  armed;
    logic [7:0]            cnt;
    logic [IDX_W-1:0]      idx_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic                  hit_any;
    logic [IDX_W-1:0]      win_idx;
    logic [ADDR_WIDTH-1:0] win_off;
    logic                  accept;
    logic                  sel_ready;
    logic                  timed_out;

    // Address decode; scanning from the top index down lets the lowest hit win.
    always_comb begin
        hit_any = 1'b0;
        win_idx = '0;
        win_off = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((bus_addr >> SIZE_LOG2[i*5 +: 5]) ==
                (BASE_ADDRS[i*ADDR_WIDTH +: ADDR_WIDTH] >> SIZE_LOG2[i*5 +: 5])) begin
                hit_any = 1'b1;
                win_idx = IDX_W'(i);
                win_off = bus_addr - BASE_ADDRS[i*ADDR_WIDTH +: ADDR_WIDTH];
            end
        end
    end

    assign accept    = (state == IDLE) && armed && (read || write);
    assign sel_ready = s_ready[idx_q];
    assign timed_out = (cnt + 8'd1) == TIMEOUT_CNT;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state decode and master-side completion outputs.
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        error      = 1'b0;
        bus_rdata  = '0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if ((read && write) || !hit_any) state_next = ERR;
                    else                             state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (sel_ready)      state_next = RESP;
                else if (timed_out) state_next = ERR;
            end
            RESP: begin
                ready      = 1'b1;
                bus_rdata  = rdata_q;
                state_next = IDLE;
            end
            ERR: begin
                ready      = 1'b1;
                error      = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request latching, registered slave strobes, wait counter and error log.
    always_ff @(posedge clk) begin
        if (reset) begin
            armed     <= 1'b1;
            cnt       <= '0;
            idx_q     <= '0;
            addr_q    <= '0;
            rdata_q   <= '0;
            s_sel     <= '0;
            s_addr    <= '0;
            s_wdata   <= '0;
            s_read    <= 1'b0;
            s_write   <= 1'b0;
            err_addr  <= '0;
            err_count <= '0;
        end else begin
            // A completion disarms; an idle master (no request) re-arms.
            if (ready) armed <= 1'b0;
            if (!read && !write) armed <= 1'b1;

            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q <= bus_addr;
                        idx_q  <= win_idx;
                        cnt    <= '0;
                        if (state_next == ACCESS) begin
                            s_sel   <= NUM_SLAVES'(1) << win_idx;
                            s_addr  <= win_off;
                            s_wdata <= write ? bus_wdata : '0;
                            s_read  <= read;
                            s_write <= write;
                        end
                    end
                end
                ACCESS: begin
                    cnt <= cnt + 8'd1;
                    if (sel_ready)
                        rdata_q <= s_read ? s_rdata[idx_q*DATA_WIDTH +: DATA_WIDTH] : '0;
                    if (state_next != ACCESS) begin
                        s_sel   <= '0;
                        s_addr  <= '0;
                        s_wdata <= '0;
                        s_read  <= 1'b0;
                        s_write <= 1'b0;
                    end
                end
                ERR: begin
                    err_addr <= addr_q;
                    if (err_count != 8'd255) err_count <= err_count + 8'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_interconnect.sv
// Bench for bus_interconnect: directed scenarios plus randomized accesses,
// each checked against a region/latency model derived from address ranges.
module tb_bus_interconnect;

    localparam int AW = 20;
    localparam int DW = 16;
    localparam int NS = 4;
    localparam int TOUT = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic [DW-1:0] bus_rdata;
    logic          read;
    logic          write;
    logic          ready;
    logic          error;
    logic [NS-1:0] s_sel;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata;
    logic          s_read;
    logic          s_write;
    logic [NS*DW-1:0] s_rdata;
    logic [NS-1:0] s_ready;
    logic [AW-1:0] err_addr;
    logic [7:0]    err_count;

    int tests = 0;
    int failed = 0;

    // Region map as plain address ranges.
    int base_tab [NS] = '{32'h00000, 32'h08000, 32'h08010, 32'h0FF00};
    int size_tab [NS] = '{2048, 16, 16, 256};

    int            m_err_count = 0;
    logic [AW-1:0] m_err_addr = '0;

    bus_interconnect dut (
        .clk       (clk),
        .reset     (reset),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .read      (read),
        .write     (write),
        .ready     (ready),
        .error     (error),
        .s_sel     (s_sel),
        .s_addr    (s_addr),
        .s_wdata   (s_wdata),
        .s_read    (s_read),
        .s_write   (s_write),
        .s_rdata   (s_rdata),
        .s_ready   (s_ready),
        .err_addr  (err_addr),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end of run, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One complete master access with a responding slave model; checks every
    // observable result against the range-based model.
    task automatic run_txn(input string tag, input logic rd, input logic wr,
                           input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                           input logic [DW-1:0] sd, input int waits);
        int a, exp_idx, exp_lat, exp_sel, lat, acc_j, bad_sel;
        bit hit, decode_err, tout, exp_err;
        logic [NS-1:0] oh;
        logic [DW-1:0] exp_rd, got_rdata, got_wd;
        logic [AW-1:0] exp_off, got_addr;
        logic got_err, got_r, got_w;

        a = int'(addr);
        hit = 0;
        exp_idx = 0;
        for (int k = NS - 1; k >= 0; k--)
            if (a >= base_tab[k] && a < base_tab[k] + size_tab[k]) begin
                hit = 1;
                exp_idx = k;
            end
        oh         = hit ? NS'(1 << exp_idx) : '0;
        decode_err = (rd && wr) || !hit;
        tout       = !decode_err && (waits >= TOUT);
        exp_err    = decode_err || tout;
        exp_lat    = decode_err ? 1 : (tout ? TOUT + 1 : waits + 2);
        exp_sel    = decode_err ? 0 : (tout ? TOUT : waits + 1);
        exp_rd     = (!exp_err && rd) ? sd : '0;
        exp_off    = AW'(a - base_tab[exp_idx]);

        for (int k = 0; k < NS; k++)
            s_rdata[k*DW +: DW] = (hit && k == exp_idx) ? sd : DW'($urandom);
        bus_addr  = addr;
        bus_wdata = wd;
        read      = rd;
        write     = wr;
        s_ready   = '0;

        lat = 0; acc_j = 0; bad_sel = 0;
        got_rdata = '0; got_err = 1'b0; got_addr = '0; got_r = 1'b0; got_w = 1'b0; got_wd = '0;
        for (int c = 1; c <= 60 && lat == 0; c++) begin
            @(negedge clk);
            if (s_sel != '0) begin
                if (hit && s_sel == oh) begin
                    if (acc_j == 0) begin
                        got_addr = s_addr; got_r = s_read; got_w = s_write; got_wd = s_wdata;
                    end
                    acc_j++;
                end else begin
                    bad_sel++;
                end
            end
            if (ready) begin
                lat = c;
                got_rdata = bus_rdata;
                got_err = error;
            end
            // Unselected slaves chatter on s_ready; the selected one answers after its waits.
            s_ready = NS'($urandom) & ~oh;
            if (hit && s_sel == oh && acc_j - 1 == waits) s_ready = s_ready | oh;
        end

        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_error"}, got_err, exp_err);
        check({tag, "_rdata"}, got_rdata, exp_rd);
        check({tag, "_sel_cycles"}, acc_j, exp_sel);
        check({tag, "_bad_sel"}, bad_sel, 0);
        if (exp_sel > 0) begin
            check({tag, "_s_addr"}, got_addr, exp_off);
            check({tag, "_s_read"}, got_r, rd);
            check({tag, "_s_write"}, got_w, wr);
            if (wr) check({tag, "_s_wdata"}, got_wd, wd);
        end

        if (exp_err) begin
            m_err_count = (m_err_count < 255) ? m_err_count + 1 : 255;
            m_err_addr  = addr;
        end
        s_ready = '0;
        @(negedge clk);
        check({tag, "_err_count"}, err_count, m_err_count);
        check({tag, "_err_addr"}, err_addr, m_err_addr);
        read  = 1'b0;
        write = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int n_ready, n_acc, waits, sel;
        logic [AW-1:0] addr;
        logic rd, wr;

        // Reset and idle values.
        reset = 1'b1; read = 1'b0; write = 1'b0;
        bus_addr = '0; bus_wdata = '0; s_rdata = '0; s_ready = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", ready, 0);
        check("rst_error", error, 0);
        check("rst_s_sel", s_sel, 0);
        check("rst_s_strobes", {s_read, s_write}, 0);
        check("rst_err_count", err_count, 0);
        check("rst_bus_rdata", bus_rdata, 0);
        reset = 1'b0;
        @(negedge clk);

        // Directed scenarios.
        run_txn("t1_read_s0", 1, 0, 20'h00005, 16'h0000, 16'hBEEF, 0);
        run_txn("t2_write_s2", 0, 1, 20'h08012, 16'h0155, 16'h0000, 3);
        run_txn("t3_unmapped", 1, 0, 20'h04000, 16'h0000, 16'h0000, 0);
        run_txn("t4_timeout_s3", 1, 0, 20'h0FF20, 16'h0000, 16'h0000, 100);
        run_txn("both_rd_wr", 1, 1, 20'h08001, 16'h1111, 16'h2222, 0);
        run_txn("last_wait_s1", 1, 0, 20'h0800F, 16'h0000, 16'hA5A5, TOUT - 1);

        // Request held past ready must not re-issue until dropped.
        n_ready = 0; n_acc = 0;
        s_rdata[0 +: DW] = 16'h1234;
        bus_addr = 20'h00010; read = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (ready) n_ready++;
            if (s_sel != '0) n_acc++;
            s_ready = s_sel;
        end
        read = 1'b0;
        @(negedge clk);
        s_ready = '0;
        read = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (ready) n_ready++;
            if (s_sel != '0) n_acc++;
            s_ready = s_sel;
        end
        read = 1'b0; s_ready = '0;
        @(negedge clk);
        check("t5_ready_pulses", n_ready, 2);
        check("t5_accesses", n_acc, 2);

        // Randomized mix of mapped, unmapped and timed-out accesses.
        for (int t = 0; t < 40; t++) begin
            sel = $urandom_range(0, 5);
            case (sel)
                0, 1, 2, 3: addr = AW'(base_tab[sel] + $urandom_range(0, size_tab[sel] - 1));
                4:       addr = AW'($urandom_range(32'h00800, 32'h07FFF));
                default: addr = AW'($urandom_range(32'h10000, 32'hFFFFF));
            endcase
            rd = 1'($urandom_range(0, 1));
            wr = ($urandom_range(0, 9) == 0) ? 1'b1 : ~rd;
            waits = ($urandom_range(0, 7) == 0) ? TOUT + 2 : $urandom_range(0, 3);
            run_txn("rand", rd, wr, addr, DW'($urandom), DW'($urandom), waits);
        end

        // Error counter saturation.
        for (int t = 0; t < 300; t++)
            run_txn("sat", 1, 0, AW'($urandom_range(32'h08020, 32'h0FEFF)), '0, '0, 0);
        check("sat_final_count", err_count, 255);

        // Reset in the middle of a slave2 wait aborts without a ready pulse.
        bus_addr = 20'h08013; read = 1'b1; s_ready = '0;
        @(negedge clk);
        @(negedge clk);
        check("t6_in_access", s_sel, 4'b0100);
        reset = 1'b1;
        @(negedge clk);
        check("t6_ready", ready, 0);
        check("t6_error", error, 0);
        check("t6_s_sel", s_sel, 0);
        check("t6_s_bus", {s_read, s_write, s_addr, s_wdata}, 0);
        check("t6_bus_rdata", bus_rdata, 0);
        check("t6_err_log", {err_addr, err_count}, 0);
        read = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        m_err_count = 0;
        m_err_addr = '0;
        @(negedge clk);
        run_txn("t6_after_reset", 1, 0, 20'h08014, 16'h0000, 16'h5A5A, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
